// File: rtl/cntr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cntr_pkg
// Purpose  : Shared constants and helpers for the parametrised up/down
//            counter family (direction codes, end-of-range modes and a
//            width helper used for parameter sanity checks).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cntr_pkg;

   // Direction codes carried on up_dn
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Behaviour at the ends of the count range
   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Number of bits needed to hold the largest count value, MODULUS-1.
   function automatic int cntr_width(input int modulus);
      int v;
      int w;
      v = modulus - 1;
      w = 1;
      for (int b = 1; b < 31; b++) begin
         if ((v >> b) != 0) w = b + 1;
      end
      return w;
   endfunction

endpackage : cntr_pkg
`default_nettype wire

// File: rtl/param_cntr_next.sv
`default_nettype none
// ============================================================================
// Module   : param_cntr_next
// Purpose  : Combinational next-state logic for one counter step. Given the
//            current count and direction it produces the value after a step
//            and flags whether the count sits at the end of its range in
//            that direction.
// Ports    : count       - current registered count
//            up_dn       - 1 = count up, 0 = count down
//            next_count  - count after one step (wrapped or saturated)
//            tc          - terminal count for the current direction
//            step_at_end - a step taken now would cross/hit the range end
// Revision : 1.0 - initial release
// ============================================================================
module param_cntr_next
   import cntr_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   output logic [WIDTH-1:0] next_count,
   output logic             tc,
   output logic             step_at_end
);

   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
   localparam bit               FULL_RANGE = (longint'(MODULUS) == (64'(1) << WIDTH));

   logic at_max;
   logic at_zero;

   always_comb begin
      at_max      = (count == MAX_VAL);
      at_zero     = (count == '0);
      tc          = (up_dn == DIR_UP) ? at_max : at_zero;
      step_at_end = tc;
   end

   generate
      if (FULL_RANGE && (SATURATE == MODE_WRAP)) begin : g_binary
         // Full binary range in wrap mode: natural modular arithmetic is
         // exactly the required behaviour, so no end-of-range muxing.
         always_comb begin
            next_count = (up_dn == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
         end
      end else begin : g_modulo
         always_comb begin
            next_count = count;
            if (up_dn == DIR_UP) begin
               if (at_max) next_count = (SATURATE == MODE_SAT) ? count : '0;
               else        next_count = count + WIDTH'(1);
            end else begin
               if (at_zero) next_count = (SATURATE == MODE_SAT) ? count : MAX_VAL;
               else         next_count = count - WIDTH'(1);
            end
         end
      end
   endgenerate

endmodule : param_cntr_next
`default_nettype wire

// File: rtl/param_sync_updown_cntr.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_updown_cntr
// Purpose  : Generic synchronous up/down counter with programmable modulus,
//            wrap or saturate at range ends, parallel load with clamping,
//            cascade carry chain and a sticky overflow flag.
// Ports    : clk     - clock, all state updates on rising edge
//            rst     - synchronous active-high reset
//            cnt_en  - count enable
//            load    - parallel load strobe (beats counting)
//            up_dn   - 1 = up, 0 = down
//            ci      - cascade carry/borrow in (tie 1 when standalone)
//            I       - parallel load value (clamped to MODULUS-1)
//            clr_ovf - clears the sticky overflow flag
//            count   - registered count
//            tc      - terminal count (combinational)
//            co      - cascade carry/borrow out (combinational)
//            ovf     - sticky overflow/underflow flag (registered)
// Revision : 1.0 - initial release
// ============================================================================
module param_sync_updown_cntr
   import cntr_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_en,
   input  logic             load,
   input  logic             up_dn,
   input  logic             ci,
   input  logic [WIDTH-1:0] I,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             co,
   output logic             ovf
);

   localparam bit FULL_RANGE = (longint'(MODULUS) == (64'(1) << WIDTH));

   generate
      if ((MODULUS < 2) || (cntr_width(MODULUS) > WIDTH)) begin : g_bad_param
         $error("param_sync_updown_cntr: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] load_val;
   logic             step;
   logic             step_at_end;

   param_cntr_next #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .count       (count),
      .up_dn       (up_dn),
      .next_count  (next_count),
      .tc          (tc),
      .step_at_end (step_at_end)
   );

   // Out-of-range load values clamp to the top of the range; with a full
   // binary range every value is legal and the comparator disappears.
   generate
      if (FULL_RANGE) begin : g_no_clamp
         always_comb load_val = I;
      end else begin : g_clamp
         localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
         localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
         always_comb load_val = ({1'b0, I} >= MOD_EXT) ? MAX_VAL : I;
      end
   endgenerate

   always_comb begin
      step = ~load & cnt_en & ci;
      co   = tc & step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (load)      count <= load_val;
         else if (step) count <= next_count;

         // A terminal step in the same cycle as a clear leaves the flag set.
         if (step && step_at_end) ovf <= 1'b1;
         else if (clr_ovf)        ovf <= 1'b0;
      end
   end

endmodule : param_sync_updown_cntr
`default_nettype wire

// File: tb/tb_param_sync_updown_cntr.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sync_updown_cntr
// Purpose  : Self-checking bench. Instances: a wrap counter (mod 10), a
//            saturating counter (mod 10), a full-range binary counter
//            (3 bits) and a two-digit decimal cascade. A behavioural model
//            tracks every instance as plain integers; a compare process
//            checks all outputs each cycle, and directed sections pin the
//            model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_updown_cntr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, cnt_en = 1'b0, load = 1'b0, up_dn = 1'b1, ci = 1'b1, clr_ovf = 1'b0;
   logic [3:0] I = 4'd0;

   logic [3:0] cnt_a, cnt_b, cnt_lo, cnt_hi;
   logic [2:0] cnt_n;
   logic       tc_a, co_a, ovf_a, tc_b, co_b, ovf_b, tc_n, co_n, ovf_n;
   logic       tc_lo, co_lo, ovf_lo, tc_hi, co_hi, ovf_hi;

   param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .up_dn(up_dn), .ci(ci),
      .I(I), .clr_ovf(clr_ovf), .count(cnt_a), .tc(tc_a), .co(co_a), .ovf(ovf_a));

   param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .up_dn(up_dn), .ci(ci),
      .I(I), .clr_ovf(clr_ovf), .count(cnt_b), .tc(tc_b), .co(co_b), .ovf(ovf_b));

   param_sync_updown_cntr #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_n (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .up_dn(up_dn), .ci(ci),
      .I(I[2:0]), .clr_ovf(clr_ovf), .count(cnt_n), .tc(tc_n), .co(co_n), .ovf(ovf_n));

   param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(1'b0), .up_dn(up_dn), .ci(1'b1),
      .I(4'd0), .clr_ovf(clr_ovf), .count(cnt_lo), .tc(tc_lo), .co(co_lo), .ovf(ovf_lo));

   param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(1'b0), .up_dn(up_dn), .ci(co_lo),
      .I(4'd0), .clr_ovf(clr_ovf), .count(cnt_hi), .tc(tc_hi), .co(co_hi), .ovf(ovf_hi));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int mdl_cnt(int c, int m, bit sat, bit r, bit ld, bit en, bit cin, bit up, int iv);
      if (r)  return 0;
      if (ld) return (iv >= m) ? m - 1 : iv;
      if (en && cin) begin
         if (up) return (sat && c == m - 1) ? c : (c + 1) % m;
         else    return (sat && c == 0)     ? c : (c + m - 1) % m;
      end
      return c;
   endfunction

   function automatic bit mdl_end(int c, int m, bit up);
      return up ? (c == m - 1) : (c == 0);
   endfunction

   function automatic bit mdl_ovf(bit o, int c, int m, bit r, bit ld, bit en, bit cin, bit up, bit clr);
      if (r) return 1'b0;
      if (!ld && en && cin && mdl_end(c, m, up)) return 1'b1;
      if (clr) return 1'b0;
      return o;
   endfunction

   int m_a = 0, m_b = 0, m_n = 0, m_v = 0;   // m_v: cascade value 0..99
   bit o_a = 0, o_b = 0, o_n = 0, o_lo = 0, o_hi = 0;
   bit m_valid = 0;

   always @(posedge clk) begin
      if (rst) m_valid <= 1'b1;
      m_a <= mdl_cnt(m_a, 10, 0, rst, load, cnt_en, ci, up_dn, int'(I));
      m_b <= mdl_cnt(m_b, 10, 1, rst, load, cnt_en, ci, up_dn, int'(I));
      m_n <= mdl_cnt(m_n, 8,  0, rst, load, cnt_en, ci, up_dn, int'(I) % 8);
      o_a <= mdl_ovf(o_a, m_a, 10, rst, load, cnt_en, ci, up_dn, clr_ovf);
      o_b <= mdl_ovf(o_b, m_b, 10, rst, load, cnt_en, ci, up_dn, clr_ovf);
      o_n <= mdl_ovf(o_n, m_n, 8,  rst, load, cnt_en, ci, up_dn, clr_ovf);
      // Cascade seen as one two-digit decimal number
      m_v  <= mdl_cnt(m_v, 100, 0, rst, 1'b0, cnt_en, 1'b1, up_dn, 0);
      o_lo <= mdl_ovf(o_lo, m_v % 10, 10, rst, 1'b0, cnt_en, 1'b1, up_dn, clr_ovf);
      o_hi <= mdl_ovf(o_hi, m_v, 100, rst, 1'b0, cnt_en, 1'b1, up_dn, clr_ovf);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         bit stp;
         stp = !load && cnt_en && ci;
         chk("a_count", cnt_a, m_a);
         chk("a_tc",    tc_a,  mdl_end(m_a, 10, up_dn));
         chk("a_co",    co_a,  stp && mdl_end(m_a, 10, up_dn));
         chk("a_ovf",   ovf_a, o_a);
         chk("b_count", cnt_b, m_b);
         chk("b_tc",    tc_b,  mdl_end(m_b, 10, up_dn));
         chk("b_co",    co_b,  stp && mdl_end(m_b, 10, up_dn));
         chk("b_ovf",   ovf_b, o_b);
         chk("n_count", cnt_n, m_n);
         chk("n_tc",    tc_n,  mdl_end(m_n, 8, up_dn));
         chk("n_co",    co_n,  stp && mdl_end(m_n, 8, up_dn));
         chk("n_ovf",   ovf_n, o_n);
         chk("casc_lo", cnt_lo, m_v % 10);
         chk("casc_hi", cnt_hi, m_v / 10);
         chk("casc_lo_co", co_lo, cnt_en && mdl_end(m_v % 10, 10, up_dn));
         chk("casc_hi_co", co_hi, cnt_en && mdl_end(m_v, 100, up_dn));
         chk("casc_lo_ovf", ovf_lo, o_lo);
         chk("casc_hi_ovf", ovf_hi, o_hi);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset for two edges
      rst = 1; cnt_en = 0; load = 0; up_dn = 1; ci = 1; clr_ovf = 0; I = 0;
      tick(); tick();
      chk("rst_count", cnt_a, 0);
      chk("rst_ovf",   ovf_a, 0);

      // Count up 12 edges: 1..9,0,1,2 ; ovf from the 9->0 edge on
      rst = 0; cnt_en = 1;
      chk("up_tc_at0", tc_a, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("up_count", cnt_a, k % 10);
         chk("up_tc",    tc_a,  (k % 10) == 9);
         chk("up_ovf",   ovf_a, k >= 10);
      end
      // Continue to 25 edges total: cascade shows decimal 25
      repeat (13) tick();
      chk("casc25_lo", cnt_lo, 5);
      chk("casc25_hi", cnt_hi, 2);
      chk("casc25_hico", co_hi, 0);

      // Down from load 3 (clear flag on the load edge): 3,2,1,0,9,8
      load = 1; I = 3; up_dn = 0; clr_ovf = 1;
      tick();
      chk("dn_load", cnt_a, 3);
      chk("dn_load_ovf", ovf_a, 0);
      load = 0; clr_ovf = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("dn_count", cnt_a, (k < 3) ? 2 - k : 12 - k);
         chk("dn_ovf",   ovf_a, k >= 3);
         if (k == 2) chk("dn_tc0", tc_a, 1);
      end
      cnt_en = 0; clr_ovf = 1;
      tick();
      chk("clr_ovf", ovf_a, 0);
      chk("clr_hold", cnt_a, 8);

      // Saturating instance: load 8, up 4 edges -> 9,9,9,9 with ovf on 2nd
      clr_ovf = 1; load = 1; I = 8; up_dn = 1; cnt_en = 1;
      tick();
      clr_ovf = 0; load = 0;
      tick();
      chk("sat_up1", cnt_b, 9);
      chk("sat_up1_ovf", ovf_b, 0);
      repeat (3) tick();
      chk("sat_up4", cnt_b, 9);
      chk("sat_up4_ovf", ovf_b, 1);
      load = 1; I = 1; up_dn = 0;
      tick();
      load = 0;
      tick();
      chk("sat_dn1", cnt_b, 0);
      tick();
      chk("sat_dn2", cnt_b, 0);

      // Clamp on load of 15, then load beats count
      load = 1; I = 4'hF; up_dn = 1; clr_ovf = 1;
      tick();
      chk("clamp", cnt_a, 9);
      chk("clamp_bin", cnt_n, 7);
      chk("load_blocks_co", co_a, 0);
      load = 0; clr_ovf = 0;
      tick();
      chk("wrap_after_clamp", cnt_a, 0);
      chk("wrap_ovf", ovf_a, 1);
      load = 1; I = 2;
      tick();
      chk("load_over_en", cnt_a, 2);
      chk("load_keeps_ovf", ovf_a, 1);

      // Reset beats load and count
      I = 7;
      tick();
      rst = 1; load = 1; I = 5;
      tick();
      chk("rst_prio_count", cnt_a, 0);
      chk("rst_prio_ovf",   ovf_a, 0);

      // Set wins over clear on the same edge
      rst = 0; load = 1; I = 9; clr_ovf = 1;
      tick();
      load = 0;
      tick();
      chk("set_wins_count", cnt_a, 0);
      chk("set_wins_ovf",   ovf_a, 1);
      clr_ovf = 0;

      // Randomized phase
      for (int k = 0; k < 600; k++) begin
         rst     = ($urandom_range(0, 49) == 0);
         load    = ($urandom_range(0, 7) == 0);
         cnt_en  = ($urandom_range(0, 3) != 0);
         ci      = ($urandom_range(0, 7) != 0);
         up_dn   = ($urandom_range(0, 15) < ((k / 100) % 2 == 0 ? 12 : 4));
         clr_ovf = ($urandom_range(0, 7) == 0);
         I       = 4'($urandom_range(0, 15));
         tick();
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_param_sync_updown_cntr
`default_nettype wire
